fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_if.sv | 33 +++
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Bus bundle between a FIFO read port, the stream reader and the downstream
// stream consumer.
//   en      : read enable (into reader)
//   re      : FIFO read request (from reader)
//   rddata  : FIFO read data, valid the cycle after an accepted read
//   empty   : FIFO empty flag
//   m_data  : output stream data
//   m_valid : output stream valid
//   m_ready : downstream ready
//   m_last  : final beat of a packet
//   pkt_cnt : count of completed packets
// master = the reader, slave = its environment (FIFO + consumer).
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 8);
  logic                  en;
  logic                  re;
  logic [DATA_WIDTH-1:0] rddata;
  logic                  empty;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic [15:0]           pkt_cnt;

  modport master (
    input  en, rddata, empty, m_ready,
    output re, m_data, m_valid, m_last, pkt_cnt
  );

  modport slave (
    output en, rddata, empty, m_ready,
    input  re, m_data, m_valid, m_last, pkt_cnt
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Reads words from a FIFO with one-cycle read latency and presents them as a
// valid/ready stream cut into packets of PKT_LEN beats.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : fifo_stream_reader_if.master (FIFO read side + output stream)
// A 2-entry buffer absorbs the read latency so that back-to-back beats flow at
// one per cycle; reads are only issued when a slot is guaranteed free for the
// returning word.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input logic                clk,
  input logic                rst,
  fifo_stream_reader_if.master bus
);
  localparam int             BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(PKT_LEN - 1);

  logic                  r_armed;     // low until the first edge after reset
  logic                  r_inflight;  // read accepted last cycle, data arrives now
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf0;      // head
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [BW-1:0]         r_beat;
  logic [15:0]           r_pkt_cnt;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_rd;
  logic [2:0]            w_level;

  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid & bus.m_ready;
  assign w_last  = w_valid & (r_beat == LAST_BEAT);
  // Slots committed after this edge if nothing new is read; pop implies occ>=1.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  // r_armed is cleared asynchronously, so this also holds re low during reset.
  assign w_rd    = r_armed & bus.en & ~bus.empty & (w_level < 3'd2);

  assign bus.re      = w_rd;
  assign bus.m_data  = r_buf0;
  assign bus.m_valid = w_valid;
  assign bus.m_last  = w_last;
  assign bus.pkt_cnt = r_pkt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_armed    <= 1'b1;
      r_inflight <= w_rd;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      case ({r_inflight, w_pop})
        2'b01: r_buf0 <= r_buf1;
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= bus.rddata;
          else               r_buf1 <= bus.rddata;
        end
        2'b11: begin
          // capture lands behind whatever survives the pop
          if (r_occ == 2'd1) r_buf0 <= bus.rddata;
          else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.rddata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat    <= '0;
      r_pkt_cnt <= 16'd0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
      if (w_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: streaming, backpressure, gappy FIFO,
// en drop, mid-packet reset and 16-bit packet counter wrap (PKT_LEN=1 copy).
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) mif ();
  fifo_stream_reader_if #(.DATA_WIDTH(8)) wif ();

  fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .bus(mif)
  );
  fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(1)) u_wrap (
    .clk(clk), .rst(rst), .bus(wif)
  );

  int nvec = 0;
  int nerr = 0;

  // FIFO model for the main instance: writes from the stimulus, reads by re.
  logic [7:0] mem [0:255];
  int         wp = 0;
  int         rp = 0;
  logic       force_empty = 1'b0;
  assign mif.empty = force_empty | (wp == rp);
  always @(posedge clk) begin
    if (mif.re && !mif.empty) begin
      mif.rddata <= mem[rp % 256];
      rp         <= rp + 1;
    end else begin
      mif.rddata <= 8'hEE;  // junk outside the capture cycle
    end
  end

  // Beat recorder for the main instance.
  logic [8:0] gotd [0:63];
  int         gcnt = 0;
  always @(posedge clk) begin
    if (!rst && mif.m_valid && mif.m_ready) begin
      gotd[gcnt % 64] <= {mif.m_last, mif.m_data};
      gcnt            <= gcnt + 1;
    end
  end

  // Wrap instance: never-empty FIFO, pops counted.
  assign wif.empty  = 1'b0;
  assign wif.rddata = 8'h5A;
  int wpops = 0;
  always @(posedge clk) begin
    if (!rst && wif.m_valid && wif.m_ready) wpops <= wpops + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp % 256] = d;
    wp = wp + 1;
  endtask

  task automatic wait_beats(input int base, input int n, input string tag);
    int k;
    k = 0;
    while ((gcnt - base) < n && k < 100) begin
      step(1);
      k++;
    end
    chk(tag, gcnt - base, n);
  endtask

  initial begin
    int base;
    int k;
    logic [7:0] lm;
    lm = 8'b1000_1000;

    rst = 1'b1;
    mif.en = 1'b1;
    mif.m_ready = 1'b1;
    wif.en = 1'b0;
    wif.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));

    // reset state
    step(2);
    chk("rst_re",    mif.re, 1'b0);
    chk("rst_valid", mif.m_valid, 1'b0);
    chk("rst_last",  mif.m_last, 1'b0);
    chk("rst_data",  mif.m_data, 8'h00);
    chk("rst_pkt",   mif.pkt_cnt, 16'h0000);
    rst = 1'b0;
    #1 chk("arm_re", mif.re, 1'b0);

    // streaming 0x10..0x17
    step(1);
    chk("c0_re", mif.re, 1'b1);
    chk("c0_valid", mif.m_valid, 1'b0);
    step(1);
    chk("c1_valid", mif.m_valid, 1'b0);
    step(1);
    for (int i = 0; i < 8; i++) begin
      chk("st_valid", mif.m_valid, 1'b1);
      chk("st_data",  mif.m_data, 8'(8'h10 + i));
      chk("st_last",  mif.m_last, lm[i]);
      step(1);
    end
    chk("st_idle", mif.m_valid, 1'b0);
    chk("st_pkt",  mif.pkt_cnt, 16'd2);
    chk("st_re",   mif.re, 1'b0);

    // backpressure
    mif.m_ready = 1'b0;
    base = gcnt;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    #1 chk("bp_re0", mif.re, 1'b1);
    step(1);
    chk("bp_re1", mif.re, 1'b1);
    chk("bp_v1",  mif.m_valid, 1'b0);
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", mif.m_valid, 1'b1);
      chk("bp_data",  mif.m_data, 8'h10);
      chk("bp_last",  mif.m_last, 1'b0);
      chk("bp_re",    mif.re, 1'b0);
      step(1);
    end
    mif.m_ready = 1'b1;
    wait_beats(base, 8, "bp_cnt");
    for (int i = 0; i < 8; i++) chk("bp_beat", gotd[(base + i) % 64], {lm[i], 8'(8'h10 + i)});
    step(3);
    chk("bp_nodup", gcnt - base, 8);
    chk("bp_pkt", mif.pkt_cnt, 16'd4);

    // gappy FIFO: empty toggles every cycle
    base = gcnt;
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 16; i++) begin
      force_empty = ((i % 2) == 0);
      #1 if (force_empty) chk("emp_re", mif.re, 1'b0);
      step(1);
    end
    force_empty = 1'b0;
    wait_beats(base, 4, "emp_cnt");
    for (int i = 0; i < 4; i++) chk("emp_beat", gotd[(base + i) % 64], {(i == 3), 8'(8'h20 + i)});
    chk("emp_pkt", mif.pkt_cnt, 16'd5);

    // en dropped right after an accepted read
    mif.en = 1'b0;
    base = gcnt;
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    step(1);
    chk("en0_re", mif.re, 1'b0);
    mif.en = 1'b1;
    #1 chk("en1_re", mif.re, 1'b1);
    step(1);
    mif.en = 1'b0;
    #1 chk("endrop_re", mif.re, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("enoff_re", mif.re, 1'b0);
    end
    chk("en_one",  gcnt - base, 1);
    chk("en_data", gotd[base % 64], {1'b0, 8'h30});

    // reset with one beat buffered mid-packet
    mif.m_ready = 1'b0;
    mif.en = 1'b1;
    step(1);
    mif.en = 1'b0;
    step(3);
    chk("pre_valid", mif.m_valid, 1'b1);
    chk("pre_data",  mif.m_data, 8'h31);
    #2 rst = 1'b1;
    #1;
    chk("rstm_valid", mif.m_valid, 1'b0);
    chk("rstm_pkt",   mif.pkt_cnt, 16'd0);
    chk("rstm_last",  mif.m_last, 1'b0);
    chk("rstm_re",    mif.re, 1'b0);
    chk("rstm_data",  mif.m_data, 8'h00);
    wp = rp;  // flush the FIFO model as well
    step(1);
    rst = 1'b0;
    mif.m_ready = 1'b1;
    base = gcnt;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    mif.en = 1'b1;
    wait_beats(base, 4, "rpk_cnt");
    for (int i = 0; i < 4; i++) chk("rpk_beat", gotd[(base + i) % 64], {(i == 3), 8'(8'h40 + i)});
    step(2);
    chk("rpk_pkt", mif.pkt_cnt, 16'd1);

    // pkt_cnt wrap with PKT_LEN=1
    wif.en = 1'b1;
    k = 0;
    while (wpops < 65535 && k < 70000) begin
      step(1);
      k++;
    end
    wif.m_ready = 1'b0;
    chk("wrap_pops",  wpops, 65535);
    chk("wrap_ffff",  wif.pkt_cnt, 16'hFFFF);
    chk("wrap_valid", wif.m_valid, 1'b1);
    chk("wrap_last",  wif.m_last, 1'b1);
    wif.m_ready = 1'b1;
    step(1);
    wif.m_ready = 1'b0;
    #1;
    chk("wrap_pops2", wpops, 65536);
    chk("wrap_zero",  wif.pkt_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
